// File: rtl/ieeedrv_sd_arbiter.sv
// Round-robin arbiter sharing one SD host block-request port among several
// track-loader requesters; latches the winner's LBA/count and routes the host ack back.
module ieeedrv_sd_arbiter #(
    parameter int PORTS = 2,
    parameter int GW    = (PORTS > 2) ? $clog2(PORTS) : 1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [31:0]      req_lba [PORTS],
    input  logic [5:0]       req_blk_cnt [PORTS],
    input  logic [PORTS-1:0] req_rd,
    input  logic [PORTS-1:0] req_wr,
    output logic [PORTS-1:0] req_ack,
    output logic [31:0]      host_lba,
    output logic [5:0]       host_blk_cnt,
    output logic             host_rd,
    output logic             host_wr,
    input  logic             host_ack,
    output logic [GW-1:0]    grant,
    output logic             busy
);

    // state | meaning
    // IDLE  | no transaction; pick next pending requester round-robin
    // REQ   | host_rd/host_wr asserted, waiting for host_ack to rise
    // XFER  | transfer running, waiting for host_ack to fall
    // FLUSH | after reset, waiting out any ack left over from an abandoned transfer
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_FLUSH
    } state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     last, last_nxt;
    logic [GW-1:0]     grant_nxt;
    logic [31:0]       lba_nxt;
    logic [5:0]        cnt_nxt;
    logic              rd_nxt, wr_nxt;
    logic [PORTS-1:0]  pending;
    logic [GW-1:0]     pick;
    logic              pick_valid;

    assign pending = req_rd | req_wr;
    assign busy    = (state != S_IDLE);

    // Walk offsets from farthest to nearest so the first pending port after last wins.
    always_comb begin
        logic [GW:0] sum;
        sum        = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = PORTS; k >= 1; k--) begin
            sum = {1'b0, last} + (GW+1)'(k);
            if (sum >= (GW+1)'(PORTS))
                sum = sum - (GW+1)'(PORTS);
            if (pending[sum[GW-1:0]]) begin
                pick       = sum[GW-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        grant_nxt = grant;
        lba_nxt   = host_lba;
        cnt_nxt   = host_blk_cnt;
        rd_nxt    = host_rd;
        wr_nxt    = host_wr;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_nxt = pick;
                    lba_nxt   = req_lba[pick];
                    cnt_nxt   = req_blk_cnt[pick];
                    wr_nxt    = req_wr[pick];
                    rd_nxt    = req_rd[pick] & ~req_wr[pick];
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (host_ack) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (!host_ack) begin
                    last_nxt  = grant;
                    state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (!host_ack)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= S_FLUSH;
            last         <= GW'(PORTS - 1);
            grant        <= '0;
            host_lba     <= '0;
            host_blk_cnt <= '0;
            host_rd      <= 1'b0;
            host_wr      <= 1'b0;
        end else begin
            state        <= state_nxt;
            last         <= last_nxt;
            grant        <= grant_nxt;
            host_lba     <= lba_nxt;
            host_blk_cnt <= cnt_nxt;
            host_rd      <= rd_nxt;
            host_wr      <= wr_nxt;
        end
    end

    always_comb begin
        req_ack = '0;
        if (state == S_REQ || state == S_XFER)
            req_ack[grant] = host_ack;
    end

endmodule

// File: doc/ieeedrv_sd_arbiter.md
# ieeedrv_sd_arbiter

Round-robin arbiter that shares one MiSTer SD host block-request port among several track-loader requesters. Typical requesters are the per-subdrive `sd_rd`/`sd_wr` request lines of two IEEE drive units in a dual-unit configuration. It grants one requester at a time and latches that requester's LBA and block count. It drives the single host request and mirrors the host acknowledge back to the granted requester only. The block sits between the drive track loaders and the top-level SD image slot.

## Interface
- `PORTS`, default 2: number of requesters, 2..8.
- `GW`, default `$clog2(PORTS)` (minimum 1): width of the grant index.

Ports:
- `clk_sys`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_lba[PORTS]`  in  32: start LBA per requester. Must be valid while that requester's `req_rd` or `req_wr` is high.
- `req_blk_cnt[PORTS]`  in  6: block count minus one, per requester.
- `req_rd`  in  PORTS: read request per requester. Level signal, held until that requester's `req_ack` is seen.
- `req_wr`  in  PORTS: write request per requester. Same rules as `req_rd`.
- `req_ack`  out  PORTS: per-requester acknowledge. Equals `host_ack` on the granted bit, 0 on all others.
- `host_lba`  out  32: latched LBA for the host.
- `host_blk_cnt`  out  6: latched block count for the host.
- `host_rd`  out  1: read request to the host.
- `host_wr`  out  1: write request to the host.
- `host_ack`  in  1: host acknowledge. High for the duration of the transfer.
- `grant`  out  GW: index of the current or last-served requester.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
States: IDLE, REQ, XFER, FLUSH.

- A requester is pending when `req_rd[i] | req_wr[i]` is high.
- **IDLE**
  - If any requester is pending, select the first pending index, searching `last+1, last+2, …` modulo PORTS.
  - Register `grant`, `host_lba`, `host_blk_cnt`, and `host_wr = req_wr[i]`, `host_rd = req_rd[i] & ~req_wr[i]`, then go to REQ.
  - If a requester has both rd and wr set, a write is issued and rd is ignored. The requester must clear both on ack.
- **REQ**
  - Hold `host_rd`/`host_wr`.
  - When `host_ack` is sampled high: clear `host_rd`/`host_wr` and go to XFER.
  - A requester withdrawing its request in this state does not cancel the transaction.
- **XFER**
  - When `host_ack` is sampled low: set `last = grant` and go to IDLE.
- **FLUSH**
  - Entered only from reset. Go to IDLE on the first cycle `host_ack` is sampled low.
- `req_ack[grant] = host_ack` in states REQ and XFER; 0 in IDLE and FLUSH. This output is combinational.
- `host_lba`, `host_blk_cnt` and `grant` are updated only on the IDLE→REQ transition. They hold their values otherwise.
- A new or changed request from a non-granted port while busy is not observed until IDLE.

## Timing
- **Reset**
  - Forces state to FLUSH, `host_rd = host_wr = 0`, `host_lba = 0`, `host_blk_cnt = 0`, `grant = 0`, `last = PORTS-1`.
  - `busy` is 1 during FLUSH; `req_ack` is 0.
  - With `host_ack` low, IDLE is reached one cycle after reset deasserts.
  - Reset during REQ or XFER abandons the transaction. No new grant is issued until the host drops `host_ack`.
- **Grant latency:** a request is sampled pending in IDLE at edge k, and `host_rd`/`host_wr` are high from edge k onward (one cycle).
- **Ack response:** `host_ack` sampled high at edge k gives `host_rd`/`host_wr` low after edge k.
- **Turnaround:** `host_ack` sampled low at edge k gives IDLE after edge k. The next grant is at edge k+1 at the earliest, so there is at least one IDLE cycle between transactions.
- **Fairness:** with all ports continuously pending, grants rotate 0,1,…,PORTS-1,0.
- **Starvation:** no port waits more than PORTS-1 transactions.

## Test plan
- **Single read:** after reset, port 1 asserts `req_rd` with `req_lba = 0x0000_0123` and `req_blk_cnt = 28`.
  - Required: `host_rd` high one cycle later, `host_lba = 0x123`, `host_blk_cnt = 28`, `grant = 1`.
  - Then host acks for 10 cycles: `req_ack = 2'b10` for those 10 cycles, `host_rd` drops the cycle after ack rises, `busy` falls the cycle after ack falls.
- **Simultaneous requests:** ports 0 and 1 both request at the same edge after reset.
  - Required: port 0 is served first, port 1 next, with exactly one IDLE cycle between them. `req_ack[1]` stays 0 during port 0's transfer.
- **Round-robin:** with PORTS = 4, ports 0, 2 and 3 continuously pending for 6 transactions.
  - Required grant order: 0, 2, 3, 0, 2, 3.
- **Read and write together:** port 0 has both rd and wr set.
  - Required: `host_wr = 1` and `host_rd = 0`.
  - Separately, port 0 drops `req_wr` in REQ before ack: `host_wr` stays high until `host_ack`, and `host_lba` is unchanged.
- **Reset mid-transfer:** assert reset in XFER while `host_ack` is high; deassert reset; keep `host_ack` high 5 more cycles while port 1 requests.
  - Required: no `host_rd`/`host_wr` during those 5 cycles, `req_ack = 0`, and port 1 is granted 2 edges after `host_ack` falls.
